// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generator, one-cycle instruction memory interface and head-of-queue buffer to decode.
// Define FETCH_STAGE_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h00400000),
  parameter int unsigned       PC_INC   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_W-1:0]        inst_data,
  output logic [ADDR_W-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] resp_pc_q;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic              resp_valid;
  logic              fifo_empty;
  logic              bypass;
  logic              push;
  logic              fifo_pop;
  logic [CNT_W:0]    credit_used;

  // A response is live only if its request was issued and no redirect kills it this cycle.
  assign resp_valid  = inflight_q && !redirect_valid;
  assign fifo_empty  = (count_q == '0);
  assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

`ifdef FETCH_STAGE_BYPASS_EN
  assign bypass = fifo_empty && resp_valid;
`else
  assign bypass = 1'b0;
`endif

  // Reset gates the request combinationally so it drops the moment reset asserts.
  assign imem_req   = reset && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_addr  = pc_q;
  assign fifo_count = count_q;

  always_comb begin
    inst_valid = 1'b0;
    inst_data  = '0;
    inst_pc    = '0;
    if (!fifo_empty) begin
      inst_valid = 1'b1;
      inst_data  = mem_data_q[rptr_q];
      inst_pc    = mem_pc_q[rptr_q];
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst_data  = imem_data;
      inst_pc    = resp_pc_q;
    end
  end

  assign fifo_pop = inst_valid && inst_ready && !redirect_valid && !fifo_empty;
  assign push     = resp_valid && !(bypass && inst_ready);

  always_comb begin
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (imem_req) pc_d = pc_q + PC_STEP;
      if (push)     wptr_d = wptr_q + PTR_W'(1);
      if (fifo_pop) rptr_d = rptr_q + PTR_W'(1);
      case ({push, fifo_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      resp_pc_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      if (imem_req) resp_pc_q <= pc_q;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through a non-zero count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc_q[wptr_q]   <= resp_pc_q;
      mem_data_q[wptr_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency/reset/stall/redirect scenarios plus randomized ready and redirects,
// with an in-order instruction-stream model feeding a scoreboard queue.
module tb_fetch_stage;

`ifdef FETCH_STAGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT_RST = BYP ? 1 : 2;
  localparam int LAT_RD  = BYP ? 2 : 3;
  localparam logic [31:0] RST_PC = 32'h00400000;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc;

  fetch_stage #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(RST_PC), .PC_INC(4)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fifo_count(fifo_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C3CA5A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // reference model: the decoded stream is consecutive words starting at the last reset/redirect target
  function automatic void refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back({model_pc, mem_f(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] start);
    exp_q.delete();
    model_pc = start;
    refill();
  endfunction

  // instruction memory: answers one cycle after a request, garbage otherwise
  logic        req_seen;
  logic [31:0] addr_seen;
  initial req_seen = 1'b0;
  always @(negedge clock) begin
    req_seen  = imem_req;
    addr_seen = imem_addr;
  end
  always @(posedge clock) begin
    #1;
    imem_data = req_seen ? mem_f(addr_seen) : $urandom;
  end

  // monitor: every presented head must match the model front; pop on accept
  always @(negedge clock) begin
    if (reset && !redirect_valid && inst_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 64'd0, 64'd1);
      end else begin
        check("inst_pc", {32'd0, inst_pc}, {32'd0, exp_q[0][63:32]});
        check("inst_data", {32'd0, inst_data}, {32'd0, exp_q[0][31:0]});
        if (inst_ready) begin
          void'(exp_q.pop_front());
          refill();
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    restart(target);
    next_cycle();
    redirect_valid = 1'b0;
  endtask

  logic saw_req;

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    restart(RST_PC);

    repeat (3) @(negedge clock);
    check("rst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_count", {61'd0, fifo_count}, 64'd0);
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_addr", {32'd0, imem_addr}, {32'd0, RST_PC});
    check("rst_pc", {32'd0, inst_pc}, 64'd0);
    check("rst_data", {32'd0, inst_data}, 64'd0);

    // release and stream with ready high
    next_cycle();
    reset      = 1'b1;
    inst_ready = 1'b1;
    restart(RST_PC);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 0) begin
        check("first_req", {63'd0, imem_req}, 64'd1);
        check("first_addr", {32'd0, imem_addr}, {32'd0, RST_PC});
      end
      check("rel_valid", {63'd0, inst_valid}, {63'd0, (c >= LAT_RST)});
      check("rel_count", {61'd0, fifo_count}, (!BYP && c >= 2) ? 64'd1 : 64'd0);
      next_cycle();
    end

    // asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", {63'd0, inst_valid}, 64'd0);
    check("async_count", {61'd0, fifo_count}, 64'd0);
    check("async_req", {63'd0, imem_req}, 64'd0);
    check("async_addr", {32'd0, imem_addr}, {32'd0, RST_PC});

    // stall: buffer fills to DEPTH and requests stop
    next_cycle();
    reset      = 1'b1;
    inst_ready = 1'b0;
    restart(RST_PC);
    repeat (7) next_cycle();
    @(negedge clock);
    check("full_count", {61'd0, fifo_count}, 64'd4);
    check("full_req", {63'd0, imem_req}, 64'd0);
    check("full_addr", {32'd0, imem_addr}, 64'h00400010);
    next_cycle();
    inst_ready = 1'b1;
    saw_req    = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (imem_req) saw_req = 1'b1;
      next_cycle();
    end
    check("resume_req", {63'd0, saw_req}, 64'd1);

    // redirect with a response in flight
    do_redirect(32'h00400100);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check("rd_count", {61'd0, fifo_count}, 64'd0);
        check("rd_addr", {32'd0, imem_addr}, 64'h00400100);
        check("rd_req", {63'd0, imem_req}, 64'd1);
      end
      check("rd_valid", {63'd0, inst_valid}, {63'd0, (k >= LAT_RD)});
      next_cycle();
    end
    repeat (4) next_cycle();

    // address wrap
    do_redirect(32'hFFFFFFF8);
    repeat (8) next_cycle();

    // randomized ready and redirects
    for (int c = 0; c < 800; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'hFFFFFFFC;
        restart(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      next_cycle();
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    repeat (10) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
